mux16_rr_arbiter: RTL and testbench

//  Shares one 16-bit 2-to-1 mux datapath (mux16) between two requesters, A and B.

---
 rtl/arb_pkg.sv | 14 +
 rtl/mux16.sv | 11 +
 rtl/mux16_rr_arbiter.sv | 109 ++++++++++
 tb/tb_mux16_rr_arbiter.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared encodings for the round-robin mux16 arbiter: source ids, output-stage
// states and the burst counter width.
package arb_pkg;

    localparam logic SRC_A   = 1'b0;
    localparam logic SRC_B   = 1'b1;
    localparam int   BURST_W = 4;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

endpackage

// File: rtl/mux16.sv
// Shared 16-bit 2-to-1 datapath mux; sel=0 passes a, sel=1 passes b.
module mux16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        sel,
    output logic [15:0] y
);

    assign y = sel ? b : a;

endmodule

// File: rtl/mux16_rr_arbiter.sv
// Two-requester round-robin arbiter with bounded bursts in front of a shared
// mux16, feeding a one-entry registered output stage with valid/ready.
module mux16_rr_arbiter
    import arb_pkg::*;
#(
    parameter int BURST = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] a_data,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [15:0] b_data,
    input  logic        b_valid,
    output logic        b_ready,
    output logic [15:0] out_data,
    output logic        out_src,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        grant_sel
);

    localparam logic [BURST_W-1:0] BURST_L = BURST_W'(BURST);

    state_e             state_q, state_d;
    logic [15:0]        out_data_q, out_data_d;
    logic               out_src_q, out_src_d;
    logic               last_q, last_d;
    logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;

    logic        grant_any;
    logic        grant;
    logic        can_load;
    logic        xfer;
    logic [15:0] mux_y;

    // burst_cnt==0 only occurs straight out of reset: no burst is running yet,
    // so a tie goes to the side that is not last (A).
    always_comb begin
        grant_any = a_valid || b_valid;
        grant     = last_q;
        if (a_valid && b_valid) begin
            if (burst_cnt_q != '0 && burst_cnt_q < BURST_L)
                grant = last_q;
            else
                grant = ~last_q;
        end else if (a_valid) begin
            grant = SRC_A;
        end else if (b_valid) begin
            grant = SRC_B;
        end
    end

    assign can_load  = (state_q == ST_EMPTY) || out_ready;
    // Readies are forced low while reset is held, since the stage reads EMPTY then.
    assign a_ready   = rst_n && can_load && grant_any && (grant == SRC_A);
    assign b_ready   = rst_n && can_load && grant_any && (grant == SRC_B);
    assign xfer      = a_ready || b_ready;
    assign grant_sel = grant;

    mux16 u_mux (
        .a   (a_data),
        .b   (b_data),
        .sel (grant_sel),
        .y   (mux_y)
    );

    always_comb begin
        state_d     = state_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        last_d      = last_q;
        burst_cnt_d = burst_cnt_q;
        if (xfer) begin
            state_d    = ST_FULL;
            out_data_d = mux_y;
            out_src_d  = grant;
            if (grant == last_q) begin
                burst_cnt_d = (burst_cnt_q >= BURST_L) ? BURST_L : burst_cnt_q + 1'b1;
            end else begin
                last_d      = grant;
                burst_cnt_d = BURST_W'(1);
            end
        end else if (state_q == ST_FULL && out_ready) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            out_data_q  <= 16'h0000;
            out_src_q   <= SRC_A;
            last_q      <= SRC_B;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            last_q      <= last_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    assign out_valid = (state_q == ST_FULL);
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Scoreboard bench: two arbiters (BURST=1 and BURST=3) share stimulus; a
// reference model predicts readies/grants and queues expected output words.
module tb_mux16_rr_arbiter;

    localparam int NI = 2;

    typedef struct {
        logic [15:0] d;
        logic        s;
    } word_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] a_data = 16'h0, b_data = 16'h0;
    logic        a_valid = 1'b0, b_valid = 1'b0, out_ready = 1'b0;

    logic        a_rdy [NI];
    logic        b_rdy [NI];
    logic [15:0] o_data[NI];
    logic        o_src [NI];
    logic        o_vld [NI];
    logic        g_sel [NI];

    int    checks = 0;
    int    errors = 0;
    int    m_last[NI];
    int    m_cnt [NI];
    bit    m_occ [NI];
    word_t sbq0[$];
    word_t sbq1[$];

    always #5 clk = ~clk;

    mux16_rr_arbiter #(.BURST(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .a_data(a_data), .a_valid(a_valid), .a_ready(a_rdy[0]),
        .b_data(b_data), .b_valid(b_valid), .b_ready(b_rdy[0]),
        .out_data(o_data[0]), .out_src(o_src[0]), .out_valid(o_vld[0]),
        .out_ready(out_ready), .grant_sel(g_sel[0])
    );

    mux16_rr_arbiter #(.BURST(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .a_data(a_data), .a_valid(a_valid), .a_ready(a_rdy[1]),
        .b_data(b_data), .b_valid(b_valid), .b_ready(b_rdy[1]),
        .out_data(o_data[1]), .out_src(o_src[1]), .out_valid(o_vld[1]),
        .out_ready(out_ready), .grant_sel(g_sel[1])
    );

    function automatic int burst_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    task automatic check(input string name, input int inst, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d: got %h expected %h at %0t", name, inst, act, exp, $time);
        end
    endtask

    // Reference model: readies/grant follow from round-robin rules on plain ints.
    task automatic model_step(input int i);
        int    burst, g, exp_sel;
        bit    any, canld, ea, eb;
        word_t w;
        burst = burst_of(i);
        if (!rst_n) begin
            check("rst_out_valid", i, 32'(o_vld[i]), 32'd0);
            check("rst_a_ready", i, 32'(a_rdy[i]), 32'd0);
            check("rst_b_ready", i, 32'(b_rdy[i]), 32'd0);
            m_last[i] = 1;
            m_cnt[i]  = 0;
            m_occ[i]  = 0;
            if (i == 0) sbq0.delete(); else sbq1.delete();
            return;
        end
        check("out_valid", i, 32'(o_vld[i]), 32'(m_occ[i]));
        any = a_valid || b_valid;
        if (a_valid && b_valid)
            g = (m_cnt[i] > 0 && m_cnt[i] < burst) ? m_last[i] : 1 - m_last[i];
        else
            g = a_valid ? 0 : 1;
        canld   = !m_occ[i] || out_ready;
        ea      = canld && any && (g == 0);
        eb      = canld && any && (g == 1);
        exp_sel = any ? g : m_last[i];
        check("a_ready", i, 32'(a_rdy[i]), 32'(ea));
        check("b_ready", i, 32'(b_rdy[i]), 32'(eb));
        check("grant_sel", i, 32'(g_sel[i]), 32'(exp_sel));
        if (ea || eb) begin
            w.d = (g == 1) ? b_data : a_data;
            w.s = (g == 1);
            if (i == 0) sbq0.push_back(w); else sbq1.push_back(w);
            m_occ[i] = 1;
            if (g == m_last[i] && m_cnt[i] > 0) begin
                m_cnt[i] = (m_cnt[i] + 1 > burst) ? burst : m_cnt[i] + 1;
            end else begin
                m_last[i] = g;
                m_cnt[i]  = 1;
            end
        end else if (m_occ[i] && out_ready) begin
            m_occ[i] = 0;
        end
    endtask

    task automatic do_cycle(input logic rv, input logic av, input logic [15:0] ad,
                            input logic bv, input logic [15:0] bd, input logic ordy);
        @(negedge clk);
        rst_n     = rv;
        a_valid   = av;
        a_data    = ad;
        b_valid   = bv;
        b_data    = bd;
        out_ready = ordy;
        #1;
        for (int i = 0; i < NI; i++) model_step(i);
    endtask

    // Monitor: every presented word must match the scoreboard head; pop on drain.
    initial begin
        word_t w;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n) begin
                for (int i = 0; i < NI; i++) begin
                    if (o_vld[i]) begin
                        if ((i == 0 ? sbq0.size() : sbq1.size()) == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL sb_empty inst%0d: got word %h with nothing expected", i, o_data[i]);
                        end else begin
                            w = (i == 0) ? sbq0[0] : sbq1[0];
                            check("out_data", i, 32'(o_data[i]), 32'(w.d));
                            check("out_src", i, 32'(o_src[i]), 32'(w.s));
                            if (out_ready) begin
                                if (i == 0) void'(sbq0.pop_front());
                                else        void'(sbq1.pop_front());
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        do_cycle(0, 0, 16'h0, 0, 16'h0, 0);
        do_cycle(0, 0, 16'h0, 0, 16'h0, 1);
        // A alone, then let the word drain
        do_cycle(1, 1, 16'h1234, 0, 16'h0, 1);
        do_cycle(1, 0, 16'h0, 0, 16'h0, 1);
        do_cycle(1, 0, 16'h0, 0, 16'h0, 1);
        // Both valid continuously
        for (int k = 0; k < 10; k++)
            do_cycle(1, 1, 16'(16'hA000 + k), 1, 16'(16'hB000 + k), 1);
        // Backpressure for four cycles, then release
        for (int k = 0; k < 4; k++)
            do_cycle(1, 1, 16'(16'hA100 + k), 1, 16'(16'hB100 + k), 0);
        for (int k = 0; k < 3; k++)
            do_cycle(1, 1, 16'(16'hA200 + k), 1, 16'(16'hB200 + k), 1);
        // A stream, B injects 16'hBEEF
        for (int k = 0; k < 5; k++)
            do_cycle(1, 1, 16'(16'hA300 + k), 0, 16'h0, 1);
        for (int k = 0; k < 4; k++)
            do_cycle(1, 1, 16'(16'hA400 + k), 1, 16'hBEEF, 1);
        for (int k = 0; k < 5; k++)
            do_cycle(1, 1, 16'(16'hA500 + k), 0, 16'h0, 1);
        // Reset while the output stage is full, then a tie after release
        do_cycle(1, 1, 16'h5555, 0, 16'h0, 0);
        do_cycle(1, 1, 16'h5556, 0, 16'h0, 0);
        do_cycle(0, 1, 16'h5557, 1, 16'h6666, 0);
        do_cycle(0, 0, 16'h0, 0, 16'h0, 1);
        do_cycle(1, 1, 16'h7777, 1, 16'h8888, 1);
        do_cycle(1, 1, 16'h7778, 1, 16'h8889, 1);
        do_cycle(1, 0, 16'h0, 0, 16'h0, 1);
        // Randomized traffic with occasional resets
        for (int k = 0; k < 1500; k++)
            do_cycle(($urandom_range(0, 199) != 0),
                     ($urandom_range(0, 3) != 0), 16'($urandom),
                     ($urandom_range(0, 3) != 0), 16'($urandom),
                     ($urandom_range(0, 3) != 0));
        do_cycle(1, 0, 16'h0, 0, 16'h0, 1);
        do_cycle(1, 0, 16'h0, 0, 16'h0, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
